// File: rtl/wm_cycle_sequencer_if.sv
// Front-end/driver bundle for the washing-machine phase sequencer.
// temp_ok and heater are present only when WM_HEAT_EN is defined.
interface wm_cycle_sequencer_if;
  logic       start;
  logic       lid;
  logic       cancel;
  logic       water_full;
`ifdef WM_HEAT_EN
  logic       temp_ok;
  logic       heater;
`endif
  logic       fault_clear;
  logic [2:0] phase;
  logic       busy;
  logic       water_intake;
  logic       motor_en;
  logic       spin_en;
  logic       done;
  logic       fault;

  // master: coin/ready front-end side; slave: the sequencer itself
  modport master (
    output start, lid, cancel, water_full, fault_clear,
`ifdef WM_HEAT_EN
    output temp_ok,
    input  heater,
`endif
    input  phase, busy, water_intake, motor_en, spin_en, done, fault
  );

  modport slave (
    input  start, lid, cancel, water_full, fault_clear,
`ifdef WM_HEAT_EN
    input  temp_ok,
    output heater,
`endif
    output phase, busy, water_intake, motor_en, spin_en, done, fault
  );
endinterface

// File: rtl/wm_cycle_sequencer.sv
// Timed wash-cycle phase sequencer: fill, optional heat, soak, wash, rinse, spin.
// Optional heat phase enabled by defining WM_HEAT_EN.
module wm_cycle_sequencer #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned SOAK_TICKS   = 3,
  parameter int unsigned WASH_TICKS   = 5,
  parameter int unsigned RINSE_TICKS  = 2,
  parameter int unsigned SPIN_TICKS   = 3,
  parameter int unsigned FILL_TIMEOUT = 6,
  parameter int unsigned HEAT_TIMEOUT = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  wm_cycle_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StHeat  = 3'd2,
    StSoak  = 3'd3,
    StWash  = 3'd4,
    StRinse = 3'd5,
    StSpin  = 3'd6,
    StFault = 3'd7
  } state_e;

  localparam logic [15:0] PresLast  = 16'(PRESCALE - 1);
  localparam logic [15:0] SoakLast  = 16'(SOAK_TICKS - 1);
  localparam logic [15:0] WashLast  = 16'(WASH_TICKS - 1);
  localparam logic [15:0] RinseLast = 16'(RINSE_TICKS - 1);
  localparam logic [15:0] SpinLast  = 16'(SPIN_TICKS - 1);
  localparam logic [15:0] FillLast  = 16'(FILL_TIMEOUT - 1);
`ifdef WM_HEAT_EN
  localparam logic [15:0] HeatLast  = 16'(HEAT_TIMEOUT - 1);
  localparam state_e      FillNext  = StHeat;
`else
  localparam state_e      FillNext  = StSoak;
`endif

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        water_q, water_d;
  logic        motor_q, motor_d;
  logic        spin_q, spin_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
`ifdef WM_HEAT_EN
  logic        heater_q, heater_d;
`endif

  logic paused;
  logic tick;
  logic pause_d;

  function automatic logic is_active(state_e s);
    return (s != StIdle) && (s != StFault);
  endfunction

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    paused  = bus.lid && is_active(state_q);
    tick    = !paused && (presc_q == PresLast);

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.lid) state_d = StFill;
      end
      // Sensor advance beats cancel, which beats the timeout fault.
      StFill: begin
        if (!paused && bus.water_full)      state_d = FillNext;
        else if (bus.cancel)                state_d = StSpin;
        else if (tick && cnt_q == FillLast) state_d = StFault;
      end
`ifdef WM_HEAT_EN
      StHeat: begin
        if (!paused && bus.temp_ok)         state_d = StSoak;
        else if (bus.cancel)                state_d = StSpin;
        else if (tick && cnt_q == HeatLast) state_d = StFault;
      end
`endif
      StSoak: begin
        if (bus.cancel)                     state_d = StSpin;
        else if (tick && cnt_q == SoakLast) state_d = StWash;
      end
      StWash: begin
        if (bus.cancel)                     state_d = StSpin;
        else if (tick && cnt_q == WashLast) state_d = StRinse;
      end
      StRinse: begin
        if (bus.cancel)                      state_d = StSpin;
        else if (tick && cnt_q == RinseLast) state_d = StSpin;
      end
      StSpin: begin
        if (tick && cnt_q == SpinLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StFault: begin
        if (bus.fault_clear) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Counters restart on every state entry and freeze while paused.
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (state_d != state_q) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (is_active(state_q) && !paused) begin
      if (presc_q == PresLast) begin
        presc_d = '0;
        cnt_d   = cnt_q + 16'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

    // Outputs are decoded from the next state, gated by the lid as sampled now.
    pause_d  = bus.lid && is_active(state_d);
    busy_d   = is_active(state_d);
    water_d  = (state_d == StFill) && !pause_d;
    motor_d  = ((state_d == StSoak) || (state_d == StWash) || (state_d == StRinse) ||
                (state_d == StSpin)) && !pause_d;
    spin_d   = (state_d == StSpin) && !pause_d;
    fault_d  = (state_d == StFault);
`ifdef WM_HEAT_EN
    heater_d = (state_d == StHeat) && !pause_d;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      water_q  <= 1'b0;
      motor_q  <= 1'b0;
      spin_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
`ifdef WM_HEAT_EN
      heater_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      water_q  <= water_d;
      motor_q  <= motor_d;
      spin_q   <= spin_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
`ifdef WM_HEAT_EN
      heater_q <= heater_d;
`endif
    end
  end

  assign bus.phase        = state_q;
  assign bus.busy         = busy_q;
  assign bus.water_intake = water_q;
  assign bus.motor_en     = motor_q;
  assign bus.spin_en      = spin_q;
  assign bus.done         = done_q;
  assign bus.fault        = fault_q;
`ifdef WM_HEAT_EN
  assign bus.heater       = heater_q;
`endif

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Directed bench for wm_cycle_sequencer at default parameters (PRESCALE=4).
// Outputs packed as {phase[2:0], busy, water_intake, motor_en, spin_en, done, fault}.
module tb_wm_cycle_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  wm_cycle_sequencer_if bus ();

  wm_cycle_sequencer dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] E_IDLE  = {3'd0, 6'b000000};
  localparam logic [8:0] E_FILL  = {3'd1, 6'b110000};
  localparam logic [8:0] E_SOAK  = {3'd3, 6'b101000};
  localparam logic [8:0] E_WASH  = {3'd4, 6'b101000};
  localparam logic [8:0] E_RINSE = {3'd5, 6'b101000};
  localparam logic [8:0] E_SPIN  = {3'd6, 6'b101100};
  localparam logic [8:0] E_DONE  = {3'd0, 6'b000010};
  localparam logic [8:0] E_FAULT = {3'd7, 6'b000001};

  typedef struct {
    int         n;
    logic       st;
    logic       ld;
    logic       cn;
    logic       wf;
    logic       fc;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] outs();
    return {bus.phase, bus.busy, bus.water_intake, bus.motor_en, bus.spin_en,
            bus.done, bus.fault};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counts edges until phase reaches p; an expired bound yields bound+1.
  task automatic wait_phase(input logic [2:0] p, input int bound, output int cyc);
    cyc = 0;
    while (bus.phase !== p && cyc <= bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic enter_soak();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.water_full = 1'b1;
    @(negedge clk);
    bus.water_full = 1'b0;
  endtask

  initial begin
    int cyc;
    tests = 0;
    fails = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.lid         = 1'b0;
    bus.cancel      = 1'b0;
    bus.water_full  = 1'b0;
    bus.fault_clear = 1'b0;
`ifdef WM_HEAT_EN
    bus.temp_ok     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_state", 32'(outs()), 32'(E_IDLE));
    rst_n = 1'b1;

`ifndef WM_HEAT_EN
    //            n  st ld cn wf fc  expected
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_IDLE});
    vecs.push_back('{1,  1, 0, 0, 0, 0, E_FILL});
    vecs.push_back('{2,  0, 0, 0, 0, 0, E_FILL});
    vecs.push_back('{1,  0, 0, 0, 1, 0, E_SOAK});
    vecs.push_back('{11, 0, 0, 0, 0, 0, E_SOAK});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_WASH});
    vecs.push_back('{19, 0, 0, 0, 0, 0, E_WASH});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_RINSE});
    vecs.push_back('{7,  0, 0, 0, 0, 0, E_RINSE});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_SPIN});
    vecs.push_back('{11, 0, 0, 0, 0, 0, E_SPIN});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_DONE});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_IDLE});
    // fill timeout, FAULT sticky against start/cancel, then cleared
    vecs.push_back('{1,  1, 0, 0, 0, 0, E_FILL});
    vecs.push_back('{23, 0, 0, 0, 0, 0, E_FILL});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_FAULT});
    vecs.push_back('{2,  1, 0, 1, 0, 0, E_FAULT});
    vecs.push_back('{1,  0, 0, 0, 0, 1, E_IDLE});
    // start ignored with lid open
    vecs.push_back('{3,  1, 1, 0, 0, 0, E_IDLE});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_IDLE});
    // water_full beats cancel in FILL; cancel in SOAK drains via SPIN
    vecs.push_back('{1,  1, 0, 0, 0, 0, E_FILL});
    vecs.push_back('{1,  0, 0, 1, 1, 0, E_SOAK});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_SOAK});
    vecs.push_back('{1,  0, 0, 1, 0, 0, E_SPIN});
    vecs.push_back('{11, 0, 0, 0, 0, 0, E_SPIN});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_DONE});
    vecs.push_back('{1,  0, 0, 0, 0, 0, E_IDLE});

    for (int i = 0; i < vecs.size(); i++) begin
      bus.start       = vecs[i].st;
      bus.lid         = vecs[i].ld;
      bus.cancel      = vecs[i].cn;
      bus.water_full  = vecs[i].wf;
      bus.fault_clear = vecs[i].fc;
      repeat (vecs[i].n) @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    bus.start       = 1'b0;
    bus.lid         = 1'b0;
    bus.cancel      = 1'b0;
    bus.water_full  = 1'b0;
    bus.fault_clear = 1'b0;

    // lid pause of 7 cycles inside WASH
    enter_soak();
    wait_phase(3'd4, 20, cyc);
    check("soak_len", 32'(cyc), 32'd12);
    repeat (5) @(negedge clk);
    bus.lid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("pause_motor_off", 32'({bus.phase, bus.motor_en}), 32'({3'd4, 1'b0}));
    end
    bus.lid = 1'b0;
    @(negedge clk);
    check("pause_resume", 32'(outs()), 32'(E_WASH));
    wait_phase(3'd5, 30, cyc);
    check("wash_paused_len", 32'(13 + cyc), 32'd27);

    // cancel during RINSE tick 1
    repeat (5) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_to_spin", 32'(outs()), 32'(E_SPIN));
    wait_phase(3'd0, 20, cyc);
    check("drain_len", 32'(cyc), 32'd12);
    check("drain_done", 32'(outs()), 32'(E_DONE));
    @(negedge clk);
    check("done_one_cycle", 32'(outs()), 32'(E_IDLE));
`else
    // temp_ok held low: HEAT runs to its timeout with heater on
    bus.start = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.water_full = 1'b1;
    @(negedge clk);
    bus.water_full = 1'b0;
    check("heat_entry", 32'({bus.phase, bus.heater}), 32'({3'd2, 1'b1}));
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("heat_on%0d", i), 32'({bus.phase, bus.heater}), 32'({3'd2, 1'b1}));
    end
    @(negedge clk);
    check("heat_timeout", 32'({outs(), bus.heater}), 32'({E_FAULT, 1'b0}));
    bus.fault_clear = 1'b1;
    @(negedge clk);
    bus.fault_clear = 1'b0;
    check("heat_fault_clear", 32'(outs()), 32'(E_IDLE));
    bus.temp_ok = 1'b1;
`endif

    // asynchronous reset in the middle of SOAK
    enter_soak();
`ifdef WM_HEAT_EN
    @(negedge clk);
`endif
    repeat (3) @(negedge clk);
    check("pre_reset_soak", 32'(outs()), 32'(E_SOAK));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(outs()), 32'(E_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'(outs()), 32'(E_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
